gerador_entrada: RTL and testbench

- Upstream stage of the 6-bit-to-7-segment integration block.
- Produces its 6-bit `entrada` value from two debounced push-buttons (increment, decrement) or from an auto-step timer.
- The counter wraps modulo 64, so every code 0..63 reachable by the display path can be selected on the board.
- Also emits a one-cycle `mudou` pulse whenever the value changes.

---
 rtl/gerador_entrada.sv | 83 ++++++++
 tb/tb_gerador_entrada.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/gerador_entrada.sv
// Input value generator: debounced inc/dec buttons or auto-step timer drive a 6-bit
// wrapping counter; mudou pulses for one cycle whenever the registered value changes.
module gerador_entrada #(
  parameter int DEBOUNCE_CICLOS = 16,
  parameter int PASSO_AUTO      = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       modo_auto,
  output logic [5:0] entrada,
  output logic       mudou
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS) + 1;
  localparam int TW = $clog2(PASSO_AUTO + 1);

  // Bit order in the synchronizer and debounce vectors: {modo_auto, btn_dec, btn_inc}
  logic [2:0]    sync1_q, sync2_q;
  logic [1:0]    est_q, est_ant_q;
  logic [CW-1:0] cnt_q [2];
  logic [TW-1:0] timer_q, timer_d;
  logic [5:0]    entrada_q, entrada_d;
  logic          mudou_q;
  logic [1:0]    pulso;
  logic          modo_s;

  assign modo_s = sync2_q[2];
  assign pulso  = est_q & ~est_ant_q;

  always_comb begin
    entrada_d = entrada_q;
    timer_d   = '0;
    if (modo_s) begin
      if (timer_q == TW'(PASSO_AUTO - 1)) begin
        entrada_d = entrada_q + 6'd1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else if (pulso == 2'b01) begin
      entrada_d = entrada_q + 6'd1;
    end else if (pulso == 2'b10) begin
      entrada_d = entrada_q - 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      est_q     <= '0;
      est_ant_q <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
      timer_q   <= '0;
      entrada_q <= '0;
      mudou_q   <= 1'b0;
    end else begin
      sync1_q <= {modo_auto, btn_dec, btn_inc};
      sync2_q <= sync1_q;
      // A new level must persist DEBOUNCE_CICLOS consecutive samples to be accepted
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == est_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(DEBOUNCE_CICLOS - 1)) begin
          est_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
      est_ant_q <= est_q;
      timer_q   <= timer_d;
      entrada_q <= entrada_d;
      mudou_q   <= (entrada_d != entrada_q);
    end
  end

  assign entrada = entrada_q;
  assign mudou   = mudou_q;

endmodule

// File: tb/tb_gerador_entrada.sv
// Directed bench for gerador_entrada with DEBOUNCE_CICLOS=4, PASSO_AUTO=5.
module tb_gerador_entrada;

  logic       clk = 1'b0;
  logic       rst, btn_inc, btn_dec, modo_auto;
  logic [5:0] entrada;
  logic       mudou;

  int total = 0;
  int bad   = 0;
  int nmud  = 0;
  bit tog   = 1'b0;

  gerador_entrada #(.DEBOUNCE_CICLOS(4), .PASSO_AUTO(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .modo_auto (modo_auto),
    .entrada   (entrada),
    .mudou     (mudou)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance n clock edges, sampling at each following negedge; inputs change there too.
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      nmud += int'(mudou);
      if (tog) btn_inc = ~btn_inc;
    end
  endtask

  task automatic press(input bit dec);
    if (dec) btn_dec = 1'b1; else btn_inc = 1'b1;
    run(10);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    run(10);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn_inc = 1'b1; btn_dec = 1'b0; modo_auto = 1'b0;
    run(2);
    chk("rst_entrada", entrada, 0);
    chk("rst_mudou", mudou, 0);
    rst = 1'b0;
    nmud = 0;
    run(6);
    chk("rst_hold_no_early_inc", entrada, 0);
    run(1);
    chk("rst_hold_inc_edge7", entrada, 1);
    chk("rst_hold_mudou", mudou, 1);
    btn_inc = 1'b0;
    run(10);
    chk("release_no_action", entrada, 1);

    do_reset();
    chk("rst2_entrada", entrada, 0);

    // single press held 20 cycles
    nmud = 0;
    btn_inc = 1'b1;
    run(6);
    chk("inc_before_edge7", entrada, 0);
    run(1);
    chk("inc_at_edge7", entrada, 1);
    chk("inc_mudou", mudou, 1);
    run(13);
    chk("inc_no_repeat", entrada, 1);
    chk("inc_one_pulse", nmud, 1);
    btn_inc = 1'b0;
    run(10);

    // glitches of 1, 2, 3 cycles
    do_reset();
    nmud = 0;
    for (int w = 1; w <= 3; w++) begin
      btn_inc = 1'b1;
      run(w);
      btn_inc = 1'b0;
      run(5);
    end
    run(5);
    chk("glitch_entrada", entrada, 0);
    chk("glitch_mudou", nmud, 0);

    // wrap-around both ways
    nmud = 0; press(1'b1);
    chk("dec_0_to_63", entrada, 63);
    chk("dec_wrap_pulses", nmud, 1);
    nmud = 0; press(1'b0);
    chk("inc_63_to_0", entrada, 0);
    chk("inc_wrap_pulses", nmud, 1);
    nmud = 0; press(1'b1);
    chk("dec_again_63", entrada, 63);
    chk("dec_again_pulses", nmud, 1);

    // simultaneous presses cancel
    nmud = 0;
    btn_inc = 1'b1; btn_dec = 1'b1;
    run(10);
    chk("simul_entrada", entrada, 63);
    chk("simul_mudou", nmud, 0);
    btn_inc = 1'b0; btn_dec = 1'b0;
    run(10);
    chk("simul_release", entrada, 63);

    nmud = 0; press(1'b1);
    chk("set_62", entrada, 62);

    // auto mode with btn_inc toggling every cycle
    modo_auto = 1'b1;
    tog = 1'b1;
    run(6);
    chk("auto_before_step", entrada, 62);
    run(1);
    chk("auto_step1", entrada, 63);
    chk("auto_step1_mudou", mudou, 1);
    run(1);
    chk("auto_mudou_drop", mudou, 0);
    run(4);
    chk("auto_step2_wrap", entrada, 0);
    run(5);
    chk("auto_step3", entrada, 1);
    run(2);
    chk("auto_mid_interval", entrada, 1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    chk("auto_rst_entrada", entrada, 0);
    chk("auto_rst_mudou", mudou, 0);
    run(6);
    chk("auto_restart_wait", entrada, 0);
    run(1);
    chk("auto_restart_step", entrada, 1);
    tog = 1'b0;
    btn_inc = 1'b0;
    modo_auto = 1'b0;
    run(12);
    chk("leave_auto_hold", entrada, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
